store_queue_cf: RTL and testbench
=================================

Name: store_queue_cf

Overview:
- Second-generation LSU store queue: buffers stores from issue until retire, then drains them to the L1/memory interface.
- Adds to the first generation: byte enables, speculative/committed split (commit pointer), flush of uncommitted stores, valid/ready handshakes on both sides, and combinational store-to-load forwarding with per-byte youngest-match.
- Sits between LSU address generation (push), retire logic (commit/flush), the load pipe (forward lookup) and the L1 write port (drain).

Parameters:
ADDR_W, 40, word-address width (address of a DATA_W-bit aligned word)
DATA_W, 64, store data width; must be a multiple of 8
DEPTH, 32, number of entries; power of 2, at least 2
BE_W, DATA_W/8, byte-enable width (derived, not overridable)
PTR_W, $clog2(DEPTH)+1, pointer width including wrap bit (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
push_valid  in  1  new store from AGU
push_ready  out  1  entry available and no flush this cycle
push_addr  in  ADDR_W  store word address
push_data  in  DATA_W  store data
push_be  in  BE_W  byte enables
commit  in  1  retire the oldest uncommitted store
flush  in  1  discard all uncommitted stores
mem_valid  out  1  oldest committed store presented
mem_ready  in  1  memory accepts it
mem_addr  out  ADDR_W  drain address
mem_data  out  DATA_W  drain data
mem_be  out  BE_W  drain byte enables
fwd_addr  in  ADDR_W  load lookup word address
fwd_hit_be  out  BE_W  bytes supplied by queue
fwd_data  out  DATA_W  forwarded bytes; zero where not hit
fwd_full  out  1  every byte of the word hit
occupancy  out  PTR_W  allocated entries (tail-head)
committed_cnt  out  PTR_W  committed, undrained entries (cmt-head)
empty  out  1  occupancy==0
full  out  1  occupancy==DEPTH

Behaviour:
- The design uses one clock and a synchronous active-high reset. The clock port is clk and the reset port is rst.
- Pointers: head (drain), cmt (commit boundary), tail (alloc). Each is PTR_W wide with a wrap bit. Index = low bits. Invariant: head <= cmt <= tail (mod 2*DEPTH ordering).
- Reset sets head, cmt and tail to 0 and clears all entry valid bits. Output values after reset:
  - push_ready=1, mem_valid=0, fwd_hit_be=0, fwd_data=0, fwd_full=0.
  - occupancy=0, committed_cnt=0, empty=1, full=0.
  - Entry data/addr RAM is not reset.
- Push: push_ready = !full && !flush. On push_valid && push_ready, write the tail entry and increment tail. The entry is visible to forwarding and occupancy next cycle.
- Commit:
  - When commit=1 and cmt!=tail (registered values), cmt increments by 1.
  - Commit with cmt==tail is ignored. A sticky error is not required.
- Drain:
  - mem_valid = (head!=cmt). mem_addr, mem_data and mem_be come from entry[head] and are stable while mem_valid && !mem_ready.
  - On mem_valid && mem_ready, head increments and the entry is freed.
  - Drain latency is 0 cycles from the commit register update: a store committed in cycle N is presented in N+1.
- Flush:
  - Sets tail <= next value of cmt; the commit in the same cycle is applied first, then the flush.
  - Committed entries are never discarded by flush, and drain continues unaffected.
  - Push is blocked in the flush cycle.
- Simultaneous push, drain and commit are all legal in one cycle. Occupancy and committed_cnt update by the net delta. A push into a full queue is not possible (push_ready=0) even if a drain occurs that cycle.
- Forwarding:
  - Purely combinational, 0-cycle latency.
  - Searches all allocated entries (head..tail-1, both committed and uncommitted) with addr==fwd_addr.
  - Per byte b, selects the youngest matching entry whose be[b]=1. fwd_hit_be[b]=1 and fwd_data byte b is taken from that entry.
  - fwd_full = &fwd_hit_be.
  - An entry being pushed this cycle is not searched. An entry draining this cycle is still searched.
- Wrap-around: age ordering uses distance from head (idx-head mod DEPTH), so youngest-match is correct across the index wrap.
- Reset mid-operation: all in-flight stores are lost. mem_valid drops in the cycle after rst is sampled.

Decomposition:
- Shared package lsu_sq_pkg holds:
  - SQ entry struct (addr, data, be).
  - Pointer-distance and pointer-increment functions.
  - BE_W/PTR_W derivation helpers.
- One sub-module, sq_fwd_select: per-byte youngest-match priority selector. It takes the match vectors and the age rotation by head, and outputs hit_be and data.
- Pointer/handshake control stays in the top module.

Test Plan:
1. DEPTH=4. Push 4 stores (addr 0x10..0x13, be=0xFF) -> full=1, push_ready=0, occupancy=4, mem_valid=0. Commit twice -> committed_cnt=2, mem_valid=1, mem_addr=0x10.
2. mem_ready held 0 for 3 cycles then 1 -> mem_addr/data stable at 0x10 throughout. Next cycle mem_addr=0x11, occupancy=3.
3. Forwarding:
   - Push A: addr 0x20, data 0x1111..11, be 0x0F. Then push B: addr 0x20, data 0x2222..22, be 0x03.
   - Lookup 0x20 -> fwd_hit_be=0x0F, fwd_data=0x0000_0000_1111_2222, fwd_full=0.
4. Flush:
   - 3 pushed, 1 committed, then flush -> occupancy=1, committed_cnt=1, push_ready=0 in the flush cycle.
   - The committed store drains normally.
   - Commit+flush in the same cycle with 2 uncommitted -> 1 kept.
5. Wrap: cycle 10 stores through DEPTH=4 with continuous push/commit/drain (mem_ready=1) -> drained addresses in push order. Youngest-match holds when the same addr sits at indices 3 and 0.
6. Assert rst with 3 entries and mem_valid=1 -> the next cycle shows empty=1, mem_valid=0, fwd_hit_be=0, push_ready=1.

Source files
------------

// File: rtl/lsu_sq_pkg.sv
// lsu_sq_pkg
//   Shared definitions for the LSU store queue: derived-width helpers and
//   pointer arithmetic for the wrap-bit pointers used by store_queue_cf.
//   Pointer helpers work on a 32-bit carrier and mask to the requested
//   width, so callers cast the result back to their own pointer width.
package lsu_sq_pkg;

  typedef logic [31:0] sq_ptr_raw_t;

  // Byte-enable width for a given data width (one enable per byte lane).
  function automatic int unsigned sq_be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Pointer width for a given depth: index bits plus one wrap bit.
  function automatic int unsigned sq_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic sq_ptr_raw_t sq_ptr_mask(input int unsigned w);
    return (sq_ptr_raw_t'(1) << w) - sq_ptr_raw_t'(1);
  endfunction

  // p + 1 modulo 2^w.
  function automatic sq_ptr_raw_t sq_ptr_inc(input sq_ptr_raw_t p, input int unsigned w);
    return (p + sq_ptr_raw_t'(1)) & sq_ptr_mask(w);
  endfunction

  // a - b modulo 2^w; with w = PTR_W this is an entry count, with w = index
  // width it is the age of an index relative to head.
  function automatic sq_ptr_raw_t sq_ptr_dist(input sq_ptr_raw_t a, input sq_ptr_raw_t b,
                                              input int unsigned w);
    return (a - b) & sq_ptr_mask(w);
  endfunction

endpackage

// File: rtl/sq_fwd_select.sv
// sq_fwd_select
//   Per-byte youngest-match selector for store-to-load forwarding.
//   Ports:
//     match_vec  - per-entry "allocated and address matches" flags
//     head_idx   - index of the oldest entry; ages are measured from here
//     ent_be     - byte enables of every entry
//     ent_data   - data of every entry
//     hit_be     - byte lanes supplied by some matching entry
//     hit_data   - forwarded bytes, zero in lanes with no hit
module sq_fwd_select
  import lsu_sq_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic [DEPTH-1:0]             match_vec,
  input  logic [$clog2(DEPTH)-1:0]     head_idx,
  input  logic [sq_be_w(DATA_W)-1:0]   ent_be   [DEPTH],
  input  logic [DATA_W-1:0]            ent_data [DEPTH],
  output logic [sq_be_w(DATA_W)-1:0]   hit_be,
  output logic [DATA_W-1:0]            hit_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BE_W  = sq_be_w(DATA_W);

  logic [IDX_W-1:0] idx;

  // Walk entries oldest to youngest (rotated by head); a later match
  // overwrites an earlier one, so each lane ends with the youngest writer.
  always_comb begin
    hit_be   = '0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head_idx + IDX_W'(k);
      for (int b = 0; b < int'(BE_W); b++) begin
        if (match_vec[idx] && ent_be[idx][b]) begin
          hit_be[b]            = 1'b1;
          hit_data[b*8 +: 8]   = ent_data[idx][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_queue_cf.sv
// store_queue_cf
//   LSU store queue with speculative/committed split. Stores are pushed from
//   the AGU, committed in order by retire, drained in order to the L1 write
//   port, and searched combinationally by the load pipe for forwarding.
//   Ports:
//     clk, rst                    - clock, synchronous active-high reset
//     push_*                      - store allocation handshake (valid/ready)
//     commit, flush               - retire one store / drop uncommitted ones
//     mem_*                       - drain handshake toward L1
//     fwd_addr, fwd_*             - load forwarding lookup and result
//     occupancy, committed_cnt    - allocated / committed-undrained counts
//     empty, full                 - occupancy status
module store_queue_cf
  import lsu_sq_pkg::*;
#(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic [ADDR_W-1:0]           push_addr,
  input  logic [DATA_W-1:0]           push_data,
  input  logic [sq_be_w(DATA_W)-1:0]  push_be,
  input  logic                        commit,
  input  logic                        flush,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  output logic [sq_be_w(DATA_W)-1:0]  mem_be,
  input  logic [ADDR_W-1:0]           fwd_addr,
  output logic [sq_be_w(DATA_W)-1:0]  fwd_hit_be,
  output logic [DATA_W-1:0]           fwd_data,
  output logic                        fwd_full,
  output logic [sq_ptr_w(DEPTH)-1:0]  occupancy,
  output logic [sq_ptr_w(DEPTH)-1:0]  committed_cnt,
  output logic                        empty,
  output logic                        full
);

  localparam int unsigned BE_W  = sq_be_w(DATA_W);
  localparam int unsigned PTR_W = sq_ptr_w(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  // Entry layout follows this instance's widths.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } sq_entry_t;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] cmt_q,  cmt_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [DEPTH-1:0] vld_q,  vld_d;

  sq_entry_t        sq_ram_q [DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [PTR_W-1:0] occ_d;
  logic             push_fire;
  logic             mem_fire;
  logic             do_commit;

  logic [DEPTH-1:0] fwd_match;
  logic [BE_W-1:0]  ent_be   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign occupancy     = PTR_W'(sq_ptr_dist(sq_ptr_raw_t'(tail_q), sq_ptr_raw_t'(head_q), PTR_W));
  assign committed_cnt = PTR_W'(sq_ptr_dist(sq_ptr_raw_t'(cmt_q), sq_ptr_raw_t'(head_q), PTR_W));
  assign empty         = (occupancy == '0);
  assign full          = (occupancy == PTR_W'(DEPTH));

  // A drain in the same cycle does not open a slot for a push: ready looks
  // only at registered occupancy.
  assign push_ready = !full && !flush;
  assign push_fire  = push_valid && push_ready;

  assign do_commit  = commit && (cmt_q != tail_q);

  assign mem_valid  = (head_q != cmt_q);
  assign mem_fire   = mem_valid && mem_ready;
  assign mem_addr   = sq_ram_q[head_idx].addr;
  assign mem_data   = sq_ram_q[head_idx].data;
  assign mem_be     = sq_ram_q[head_idx].be;

  always_comb begin
    cmt_d  = do_commit ? PTR_W'(sq_ptr_inc(sq_ptr_raw_t'(cmt_q), PTR_W)) : cmt_q;
    head_d = mem_fire  ? PTR_W'(sq_ptr_inc(sq_ptr_raw_t'(head_q), PTR_W)) : head_q;
    // Flush trims tail back to the post-commit boundary; push cannot fire
    // in a flush cycle, so the two tail updates never collide.
    if (flush) begin
      tail_d = cmt_d;
    end else if (push_fire) begin
      tail_d = PTR_W'(sq_ptr_inc(sq_ptr_raw_t'(tail_q), PTR_W));
    end else begin
      tail_d = tail_q;
    end
    occ_d = PTR_W'(sq_ptr_dist(sq_ptr_raw_t'(tail_d), sq_ptr_raw_t'(head_d), PTR_W));
    // An index is allocated when its age from head is below occupancy.
    vld_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      vld_d[i] = sq_ptr_dist(sq_ptr_raw_t'(i), sq_ptr_raw_t'(head_d[IDX_W-1:0]), IDX_W)
                 < sq_ptr_raw_t'(occ_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  // Entry storage is write-only on push and intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      sq_ram_q[tail_idx] <= '{addr: push_addr, data: push_data, be: push_be};
    end
  end

  always_comb begin
    fwd_match = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_match[i] = vld_q[i] && (sq_ram_q[i].addr == fwd_addr);
      ent_be[i]    = sq_ram_q[i].be;
      ent_data[i]  = sq_ram_q[i].data;
    end
  end

  sq_fwd_select #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fwd_select (
    .match_vec (fwd_match),
    .head_idx  (head_idx),
    .ent_be    (ent_be),
    .ent_data  (ent_data),
    .hit_be    (fwd_hit_be),
    .hit_data  (fwd_data)
  );

  assign fwd_full = &fwd_hit_be;

endmodule

// File: tb/tb_store_queue_cf.sv
module tb_store_queue_cf;

  localparam int ADDR_W = 40;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int BE_W   = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [BE_W-1:0]   push_be;
  logic              commit;
  logic              flush;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] fwd_addr;
  logic [BE_W-1:0]   fwd_hit_be;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_full;
  logic [PTR_W-1:0]  occupancy;
  logic [PTR_W-1:0]  committed_cnt;
  logic              empty;
  logic              full;

  int n_cmp = 0;
  int n_err = 0;

  store_queue_cf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_addr     (push_addr),
    .push_data     (push_data),
    .push_be       (push_be),
    .commit        (commit),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_be        (mem_be),
    .fwd_addr      (fwd_addr),
    .fwd_hit_be    (fwd_hit_be),
    .fwd_data      (fwd_data),
    .fwd_full      (fwd_full),
    .occupancy     (occupancy),
    .committed_cnt (committed_cnt),
    .empty         (empty),
    .full          (full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0;
    commit     = 1'b0;
    flush      = 1'b0;
    mem_ready  = 1'b0;
  endtask

  // Drive one cycle of inputs, clock it, return 1 time unit after the edge
  // with inputs back at idle.
  task automatic cyc(input logic pv, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [BE_W-1:0] be, input logic cm, input logic fl, input logic mr);
    push_valid = pv;
    push_addr  = a;
    push_data  = d;
    push_be    = be;
    commit     = cm;
    flush      = fl;
    mem_ready  = mr;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    cyc(1'b1, a, d, be, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_drained;
    rst       = 1'b1;
    push_addr = '0;
    push_data = '0;
    push_be   = '0;
    fwd_addr  = 40'h20;
    idle_inputs();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // reset state
    check_eq("rst_push_ready", 64'(push_ready), 64'd1);
    check_eq("rst_mem_valid",  64'(mem_valid),  64'd0);
    check_eq("rst_fwd_hit",    64'(fwd_hit_be), 64'd0);
    check_eq("rst_fwd_data",   fwd_data,        64'd0);
    check_eq("rst_fwd_full",   64'(fwd_full),   64'd0);
    check_eq("rst_occ",        64'(occupancy),  64'd0);
    check_eq("rst_cmt_cnt",    64'(committed_cnt), 64'd0);
    check_eq("rst_empty",      64'(empty),      64'd1);
    check_eq("rst_full",       64'(full),       64'd0);

    // 1: fill to full, then commit two
    for (int i = 0; i < 4; i++) push(40'h10 + 40'(i), 64'h1000 + 64'(i), 8'hFF);
    check_eq("t1_full",       64'(full),       64'd1);
    check_eq("t1_push_ready", 64'(push_ready), 64'd0);
    check_eq("t1_occ",        64'(occupancy),  64'd4);
    check_eq("t1_mem_valid",  64'(mem_valid),  64'd0);
    push(40'h99, 64'h9999, 8'hFF);
    check_eq("t1_push_blocked_occ", 64'(occupancy), 64'd4);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("t1_cmt_cnt",   64'(committed_cnt), 64'd2);
    check_eq("t1_mem_valid2", 64'(mem_valid),    64'd1);
    check_eq("t1_mem_addr",  64'(mem_addr),      64'h10);
    check_eq("t1_mem_be",    64'(mem_be),        64'hFF);

    // 2: backpressure holds the drain entry stable
    for (int c = 0; c < 3; c++) begin
      check_eq("t2_hold_addr", 64'(mem_addr), 64'h10);
      check_eq("t2_hold_data", mem_data,      64'h1000);
      @(posedge clk);
      #2;
    end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("t2_next_addr", 64'(mem_addr),  64'h11);
    check_eq("t2_occ",       64'(occupancy), 64'd3);
    check_eq("t2_cmt_cnt",   64'(committed_cnt), 64'd1);
    check_eq("t2_push_ready", 64'(push_ready), 64'd1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("t2_drained_empty", 64'(empty), 64'd1);

    // 3: per-byte youngest-match forwarding
    fwd_addr = 40'h20;
    push(40'h20, 64'h1111_1111_1111_1111, 8'h0F);
    push(40'h20, 64'h2222_2222_2222_2222, 8'h03);
    check_eq("t3_hit_be", 64'(fwd_hit_be), 64'h0F);
    check_eq("t3_data",   fwd_data,        64'h0000_0000_1111_2222);
    check_eq("t3_full",   64'(fwd_full),   64'd0);
    fwd_addr = 40'h21;
    #1;
    check_eq("t3_miss_hit_be", 64'(fwd_hit_be), 64'h00);
    check_eq("t3_miss_data",   fwd_data,        64'h0);
    fwd_addr   = 40'h20;
    push_valid = 1'b1;
    push_addr  = 40'h20;
    push_data  = 64'h3333_3333_3333_3333;
    push_be    = 8'hF0;
    #1;
    check_eq("t3_inflight_not_seen", 64'(fwd_hit_be), 64'h0F);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_eq("t3_c_hit_be", 64'(fwd_hit_be), 64'hFF);
    check_eq("t3_c_data",   fwd_data,        64'h3333_3333_1111_2222);
    check_eq("t3_c_full",   64'(fwd_full),   64'd1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t3_flush_occ",    64'(occupancy),  64'd0);
    check_eq("t3_flush_hit_be", 64'(fwd_hit_be), 64'h00);

    // 4: flush keeps committed stores
    push(40'h30, 64'h30, 8'hFF);
    push(40'h31, 64'h31, 8'hFF);
    push(40'h32, 64'h32, 8'hFF);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    flush      = 1'b1;
    push_valid = 1'b1;
    push_addr  = 40'h3F;
    #1;
    check_eq("t4_ready_in_flush", 64'(push_ready), 64'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_eq("t4_occ",       64'(occupancy),     64'd1);
    check_eq("t4_cmt_cnt",   64'(committed_cnt), 64'd1);
    check_eq("t4_mem_valid", 64'(mem_valid),     64'd1);
    check_eq("t4_mem_addr",  64'(mem_addr),      64'h30);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("t4_drained", 64'(empty), 64'd1);
    push(40'h40, 64'h40, 8'hFF);
    push(40'h41, 64'h41, 8'hFF);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    check_eq("t4_cf_occ",      64'(occupancy),     64'd1);
    check_eq("t4_cf_cmt_cnt",  64'(committed_cnt), 64'd1);
    check_eq("t4_cf_mem_addr", 64'(mem_addr),      64'h40);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("t4_cf_empty", 64'(empty), 64'd1);

    // 5: streaming through the wrap, drains in push order
    n_drained = 0;
    for (int k = 0; k < 30 && n_drained < 10; k++) begin
      push_valid = (k < 10);
      push_addr  = 40'h50 + 40'(k);
      push_data  = 64'h500 + 64'(k);
      push_be    = 8'hFF;
      commit     = 1'b1;
      mem_ready  = 1'b1;
      #1;
      if (mem_valid) begin
        check_eq("t5_drain_addr", 64'(mem_addr), 64'h50 + 64'(n_drained));
        n_drained++;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    #1;
    check_eq("t5_drain_count", 64'(n_drained), 64'd10);
    check_eq("t5_empty",       64'(empty),     64'd1);

    // 5b: same address at index 3 (older) and index 0 (younger)
    push(40'h61, 64'h61, 8'hFF);
    push(40'h62, 64'h62, 8'hFF);
    push(40'h63, 64'h63, 8'hFF);
    for (int c = 0; c < 4; c++) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t5b_empty", 64'(empty), 64'd1);
    fwd_addr = 40'h70;
    push(40'h70, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    push(40'h70, 64'hBBBB_BBBB_BBBB_BBBB, 8'h0F);
    check_eq("t5b_hit_be", 64'(fwd_hit_be), 64'hFF);
    check_eq("t5b_data",   fwd_data,        64'hAAAA_AAAA_BBBB_BBBB);
    check_eq("t5b_full",   64'(fwd_full),   64'd1);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    #1;
    check_eq("t5b_draining_data", fwd_data, 64'hAAAA_AAAA_BBBB_BBBB);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_eq("t5b_after_hit_be", 64'(fwd_hit_be), 64'h0F);
    check_eq("t5b_after_data",   fwd_data,        64'h0000_0000_BBBB_BBBB);
    check_eq("t5b_after_full",   64'(fwd_full),   64'd0);

    // 6: reset with entries in flight
    push(40'h80, 64'h80, 8'hFF);
    push(40'h81, 64'h81, 8'hFF);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("t6_pre_occ",   64'(occupancy), 64'd3);
    check_eq("t6_pre_valid", 64'(mem_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("t6_empty",      64'(empty),      64'd1);
    check_eq("t6_mem_valid",  64'(mem_valid),  64'd0);
    check_eq("t6_fwd_hit",    64'(fwd_hit_be), 64'd0);
    check_eq("t6_push_ready", 64'(push_ready), 64'd1);
    check_eq("t6_cmt_cnt",    64'(committed_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
